// File: rtl/fwd_ctrl_pipe.sv
// Forwarding controller: tracks ID/EX, EX/MEM, MEM/WB producers and registers ALU operand selects.
// Optional load-use stall enabled by defining FWD_LOAD_STALL_EN.
module fwd_ctrl_pipe #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  flush,
  output logic [1:0]            fwd_sel_a,
  output logic [1:0]            fwd_sel_b,
  output logic                  stall,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  wb_we
);

  logic                  idex_valid;
  logic                  idex_rw;
  logic                  idex_mr;
  logic [REG_ADDR_W-1:0] idex_rd;
  logic                  exmem_valid;
  logic                  exmem_rw;
  logic [REG_ADDR_W-1:0] exmem_rd;

  logic idex_prod;
  logic exmem_prod;
  logic [1:0] sel_a_next;
  logic [1:0] sel_b_next;

  assign idex_prod  = idex_valid & idex_rw & (idex_rd != '0);
  assign exmem_prod = exmem_valid & exmem_rw & (exmem_rd != '0);

  // Newest producer (ID/EX, heading to MEM) has priority over the older EX/MEM one.
  always_comb begin
    sel_a_next = 2'b00;
    sel_b_next = 2'b00;
    if (id_valid) begin
      if (idex_prod && (idex_rd == id_rs1)) begin
        sel_a_next = 2'b01;
      end else if (exmem_prod && (exmem_rd == id_rs1)) begin
        sel_a_next = 2'b10;
      end
      if (idex_prod && (idex_rd == id_rs2)) begin
        sel_b_next = 2'b01;
      end else if (exmem_prod && (exmem_rd == id_rs2)) begin
        sel_b_next = 2'b10;
      end
    end
  end

`ifdef FWD_LOAD_STALL_EN
  assign stall = ~flush & id_valid & idex_valid & idex_mr & idex_rw & (idex_rd != '0)
                 & ((idex_rd == id_rs1) | (idex_rd == id_rs2));
`else
  // Software schedules a nop after loads, so the load flag has no consumer here.
  logic unused_mem_read;
  assign stall           = 1'b0;
  assign unused_mem_read = idex_mr;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      idex_valid  <= 1'b0;
      idex_rw     <= 1'b0;
      idex_mr     <= 1'b0;
      idex_rd     <= '0;
      exmem_valid <= 1'b0;
      exmem_rw    <= 1'b0;
      exmem_rd    <= '0;
      wb_we       <= 1'b0;
      wb_rd       <= '0;
      fwd_sel_a   <= 2'b00;
      fwd_sel_b   <= 2'b00;
    end else begin
      exmem_valid <= idex_valid;
      exmem_rw    <= idex_rw;
      exmem_rd    <= idex_rd;
      wb_we       <= exmem_prod;
      wb_rd       <= exmem_rd;
      if (flush || stall) begin
        idex_valid <= 1'b0;
        idex_rw    <= 1'b0;
        idex_mr    <= 1'b0;
        idex_rd    <= '0;
        fwd_sel_a  <= 2'b00;
        fwd_sel_b  <= 2'b00;
      end else begin
        idex_valid <= id_valid;
        idex_rw    <= id_reg_write;
        idex_mr    <= id_mem_read;
        idex_rd    <= id_rd;
        fwd_sel_a  <= sel_a_next;
        fwd_sel_b  <= sel_b_next;
      end
    end
  end

endmodule

// File: tb/tb_fwd_ctrl_pipe.sv
// Directed bench for fwd_ctrl_pipe: vector table for forwarding, hand sequences for
// load-use, flush and mid-stream reset. Expectations follow FWD_LOAD_STALL_EN when defined.
module tb_fwd_ctrl_pipe;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic [4:0] id_rd;
  logic       id_reg_write;
  logic       id_mem_read;
  logic       flush;
  logic [1:0] fwd_sel_a;
  logic [1:0] fwd_sel_b;
  logic       stall;
  logic [4:0] wb_rd;
  logic       wb_we;

  int   nCompared;
  int   nMismatched;
  logic stallSeen;

  fwd_ctrl_pipe #(.REG_ADDR_W(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .flush        (flush),
    .fwd_sel_a    (fwd_sel_a),
    .fwd_sel_b    (fwd_sel_b),
    .stall        (stall),
    .wb_rd        (wb_rd),
    .wb_we        (wb_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
    logic       flush;
    logic [1:0] ea;
    logic [1:0] eb;
    logic       ewe;
    logic [4:0] erd;
  } vec_t;

  vec_t vecs[22];

  // Drive one ID-stage slot at the falling edge, sample combinational stall, then step one edge.
  task automatic applyStimulus(input logic r, input logic v, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [4:0] rd, input logic rw,
                               input logic mr, input logic fl);
    @(negedge clk);
    rst          = r;
    id_valid     = v;
    id_rs1       = rs1;
    id_rs2       = rs2;
    id_rd        = rd;
    id_reg_write = rw;
    id_mem_read  = mr;
    flush        = fl;
    #1;
    stallSeen = stall;
    @(posedge clk);
    #1;
  endtask

  task automatic compareField(input string name, input int actual, input int expected);
    nCompared++;
    if (actual != expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // wb_rd is only meaningful while wb_we is asserted.
  task automatic checkOutput(input string tag, input logic eStall, input logic [1:0] ea,
                             input logic [1:0] eb, input logic ewe, input logic [4:0] erd);
    compareField({tag, ".stall"}, int'(stallSeen), int'(eStall));
    compareField({tag, ".sel_a"}, int'(fwd_sel_a), int'(ea));
    compareField({tag, ".sel_b"}, int'(fwd_sel_b), int'(eb));
    compareField({tag, ".wb_we"}, int'(wb_we), int'(ewe));
    if (ewe) compareField({tag, ".wb_rd"}, int'(wb_rd), int'(erd));
  endtask

  task automatic applyNops(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    nCompared    = 0;
    nMismatched  = 0;
    rst          = 1'b1;
    id_valid     = 1'b0;
    id_rs1       = 5'd0;
    id_rs2       = 5'd0;
    id_rd        = 5'd0;
    id_reg_write = 1'b0;
    id_mem_read  = 1'b0;
    flush        = 1'b0;

    //           rst v  rs1 rs2 rd  rw mr fl  ea    eb    we  wbrd
    vecs[0]  = '{1, 0, 0,  0,  0,  0, 0, 0, 2'd0, 2'd0, 0, 5'd0};
    vecs[1]  = '{0, 0, 0,  0,  0,  0, 0, 0, 2'd0, 2'd0, 0, 5'd0};
    vecs[2]  = '{0, 1, 1,  2,  5,  1, 0, 0, 2'd0, 2'd0, 0, 5'd0};
    vecs[3]  = '{0, 1, 5,  6,  8,  1, 0, 0, 2'd1, 2'd0, 0, 5'd0};
    vecs[4]  = '{0, 0, 0,  0,  0,  0, 0, 0, 2'd0, 2'd0, 1, 5'd5};
    vecs[5]  = '{0, 1, 0,  0,  7,  1, 0, 0, 2'd0, 2'd0, 1, 5'd8};
    vecs[6]  = '{0, 0, 0,  0,  0,  0, 0, 0, 2'd0, 2'd0, 0, 5'd0};
    vecs[7]  = '{0, 1, 9,  7,  10, 1, 0, 0, 2'd0, 2'd2, 1, 5'd7};
    vecs[8]  = '{0, 1, 0,  0,  3,  1, 0, 0, 2'd0, 2'd0, 0, 5'd0};
    vecs[9]  = '{0, 1, 0,  0,  3,  1, 0, 0, 2'd0, 2'd0, 1, 5'd10};
    vecs[10] = '{0, 1, 3,  3,  11, 1, 0, 0, 2'd1, 2'd1, 1, 5'd3};
    vecs[11] = '{0, 1, 0,  0,  0,  1, 0, 0, 2'd0, 2'd0, 1, 5'd3};
    vecs[12] = '{0, 1, 0,  0,  12, 1, 0, 0, 2'd0, 2'd0, 1, 5'd11};
    vecs[13] = '{0, 0, 0,  0,  0,  0, 0, 0, 2'd0, 2'd0, 0, 5'd0};
    vecs[14] = '{0, 0, 0,  0,  0,  0, 0, 0, 2'd0, 2'd0, 1, 5'd12};
    vecs[15] = '{0, 0, 0,  0,  0,  0, 0, 0, 2'd0, 2'd0, 0, 5'd0};
    vecs[16] = '{0, 1, 0,  0,  9,  1, 0, 0, 2'd0, 2'd0, 0, 5'd0};
    vecs[17] = '{0, 0, 9,  9,  9,  1, 0, 0, 2'd0, 2'd0, 0, 5'd0};
    vecs[18] = '{0, 1, 0,  0,  14, 0, 0, 0, 2'd0, 2'd0, 1, 5'd9};
    vecs[19] = '{0, 1, 14, 9,  15, 1, 0, 0, 2'd0, 2'd0, 0, 5'd0};
    vecs[20] = '{0, 0, 0,  0,  0,  0, 0, 0, 2'd0, 2'd0, 0, 5'd0};
    vecs[21] = '{0, 0, 0,  0,  0,  0, 0, 0, 2'd0, 2'd0, 1, 5'd15};

    for (int i = 0; i < 22; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].v, vecs[i].rs1, vecs[i].rs2, vecs[i].rd,
                    vecs[i].rw, vecs[i].mr, vecs[i].flush);
      checkOutput($sformatf("vec%0d", i), 1'b0, vecs[i].ea, vecs[i].eb, vecs[i].ewe, vecs[i].erd);
    end

    // Load-use: lw x4, then add rs1=x4.
    applyNops(3);
    applyStimulus(1'b0, 1'b1, 5'd1, 5'd0, 5'd4, 1'b1, 1'b1, 1'b0);
    checkOutput("lw", 1'b0, 2'd0, 2'd0, 1'b0, 5'd0);
    applyStimulus(1'b0, 1'b1, 5'd4, 5'd2, 5'd13, 1'b1, 1'b0, 1'b0);
`ifdef FWD_LOAD_STALL_EN
    checkOutput("use_stall", 1'b1, 2'd0, 2'd0, 1'b0, 5'd0);
    applyStimulus(1'b0, 1'b1, 5'd4, 5'd2, 5'd13, 1'b1, 1'b0, 1'b0);
    checkOutput("use_retry", 1'b0, 2'd2, 2'd0, 1'b1, 5'd4);
    applyNops(1);
    checkOutput("use_bubble_wb", 1'b0, 2'd0, 2'd0, 1'b0, 5'd0);
    applyNops(1);
    checkOutput("use_add_wb", 1'b0, 2'd0, 2'd0, 1'b1, 5'd13);
`else
    checkOutput("use_nostall", 1'b0, 2'd1, 2'd0, 1'b0, 5'd0);
    applyNops(1);
    checkOutput("use_lw_wb", 1'b0, 2'd0, 2'd0, 1'b1, 5'd4);
    applyNops(1);
    checkOutput("use_add_wb", 1'b0, 2'd0, 2'd0, 1'b1, 5'd13);
`endif

    // Flush of a load-dependent consumer: no stall, selects zero, squashed slot never writes.
    applyNops(3);
    applyStimulus(1'b0, 1'b1, 5'd0, 5'd0, 5'd6, 1'b1, 1'b1, 1'b0);
    checkOutput("fl_lw", 1'b0, 2'd0, 2'd0, 1'b0, 5'd0);
    applyStimulus(1'b0, 1'b1, 5'd6, 5'd6, 5'd16, 1'b1, 1'b0, 1'b1);
    checkOutput("fl_flush", 1'b0, 2'd0, 2'd0, 1'b0, 5'd0);
    applyNops(1);
    checkOutput("fl_lw_wb", 1'b0, 2'd0, 2'd0, 1'b1, 5'd6);
    applyNops(1);
    checkOutput("fl_squash_wb", 1'b0, 2'd0, 2'd0, 1'b0, 5'd0);

    // Reset mid-stream discards both in-flight writers.
    applyNops(3);
    applyStimulus(1'b0, 1'b1, 5'd0, 5'd0, 5'd20, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 5'd0, 5'd0, 5'd21, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 5'd21, 5'd20, 5'd22, 1'b1, 1'b0, 1'b0);
    checkOutput("rst_edge", 1'b0, 2'd0, 2'd0, 1'b0, 5'd0);
    applyStimulus(1'b0, 1'b1, 5'd21, 5'd20, 5'd23, 1'b1, 1'b0, 1'b0);
    checkOutput("rst_after", 1'b0, 2'd0, 2'd0, 1'b0, 5'd0);
    applyNops(1);
    checkOutput("rst_after2", 1'b0, 2'd0, 2'd0, 1'b0, 5'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
